// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-Stream sink with a small word FIFO feeding an 8N1 UART
// transmitter. Each word goes out as DATA_WIDTH/8 bytes, LSB byte first,
// frames packed back to back with no idle gap while data is available.
module axis_uart_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int NB  = DATA_WIDTH / 8;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = AW + 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CPB - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [PW-1:0] FULL_OCC  = PW'(FIFO_DEPTH);

  generate
    if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("axis_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (CPB < 2) begin : g_bad_baud
      $error("axis_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO storage and pointers (extra wrap bit separates full from empty)
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic                  push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  // Transmitter state
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  tx_q, tx_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  baud_wrap;

  assign push       = s_tvalid && tready_q;
  assign fifo_empty = (wr_q == rd_q);
  assign head       = mem_q[rd_q[AW-1:0]];
  assign baud_wrap  = (cnt_q == CNT_MAX);

  // Frame sequencing: the shifter always presents the current bit at sh_q[0];
  // after the 8th data bit the next byte of the word is already at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = head;
          byte_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          cnt_d = '0;
          bit_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + BW'(1);
            state_d = S_START;
            tx_d    = 1'b0;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = head;
            byte_d  = '0;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Pointer update plus look-ahead ready/busy, so both outputs can be registered
  always_comb begin
    wr_d     = wr_q + PW'(push);
    rd_d     = rd_q + PW'(pop);
    tready_d = ((wr_d - rd_d) != FULL_OCC);
    busy_d   = (wr_d != rd_d) || (state_d != S_IDLE);
  end

  // FIFO data write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= s_tdata;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  assign s_tready = tready_q;
  assign uart_tx  = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: a 16-bit and a 64-bit instance at 10 clk per bit.
// The expected line waveform is derived from the 8N1 frame rule by arithmetic.
module tb_axis_uart_tx;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d16 = '0;
  logic        v16 = 1'b0;
  logic        r16, tx16, b16;
  logic [63:0] d64 = '0;
  logic        v64 = 1'b0;
  logic        r64, tx64, b64;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  axis_uart_tx #(.DATA_WIDTH(16), .CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .s_tdata(d16), .s_tvalid(v16),
    .s_tready(r16), .uart_tx(tx16), .busy(b16));

  axis_uart_tx #(.DATA_WIDTH(64), .CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .s_tdata(d64), .s_tvalid(v64),
    .s_tready(r64), .uart_tx(tx64), .busy(b64));

  // Line level idx cycles into a word's frames: start 0, 8 data bits, stop 1.
  function automatic logic exp_line(input logic [63:0] w, input int idx);
    int bp  = idx / CPB;
    int by  = bp / 10;
    int pos = bp % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[by*8 + pos - 1];
  endfunction

  // Wait for a start bit, then compare every cycle of all queued words, then idle.
  task automatic stream_check(input bit sel, input int nb, input string name, output int lat);
    int waited = 0;
    int bad;
    bit first = 1'b1;
    logic [63:0] w;
    logic line;
    do begin
      @(negedge clk);
      waited++;
    end while ((sel ? tx64 : tx16) !== 1'b0 && waited < 3000);
    lat = waited;
    checks++;
    if ((sel ? tx64 : tx16) !== 1'b0) begin
      errors++;
      $display("FAIL %s start_bit: line=%b after %0d cycles, required 0", name, sel ? tx64 : tx16, waited);
      exp_q.delete();
      return;
    end
    while (exp_q.size() > 0) begin
      w   = exp_q.pop_front();
      bad = 0;
      for (int i = 0; i < nb*10*CPB; i++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        line = sel ? tx64 : tx16;
        if (line !== exp_line(w, i)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s word %h: %0d cycles off the required frame waveform, required 0", name, w, bad);
      end
    end
    @(negedge clk);
    checks++;
    if ((sel ? b64 : b16) !== 1'b0 || (sel ? tx64 : tx16) !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b line=%b, required busy=0 line=1", name,
               sel ? b64 : b16, sel ? tx64 : tx16);
    end
  endtask

  // Present one word on the 16-bit port, return at the negedge after acceptance.
  task automatic push16(input logic [15:0] w, output int waited);
    v16 = 1'b1;
    d16 = w;
    waited = 0;
    while (r16 !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (r16 !== 1'b1) begin
      errors++;
      $display("FAIL push16 ready_timeout: s_tready=%b, required 1", r16);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (tx16 !== 1'b1 || b16 !== 1'b0 || r16 !== 1'b0 || tx64 !== 1'b1 || r64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tx=%b busy=%b ready=%b tx64=%b ready64=%b, required 1 0 0 1 0",
               tx16, b16, r16, tx64, r64);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (r16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: s_tready=%b before first edge, required 0", r16);
    end
    @(negedge clk);
    checks++;
    if (r16 !== 1'b1 || r64 !== 1'b1 || b16 !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_ready: ready=%b ready64=%b busy=%b, required 1 1 0", r16, r64, b16);
    end
  endtask

  task automatic test_single();
    int w8, lat;
    exp_q.push_back(64'hA55A);
    push16(16'hA55A, w8);
    v16 = 1'b0;
    checks++;
    if (tx16 !== 1'b1 || b16 !== 1'b1) begin
      errors++;
      $display("FAIL single_accept_edge: line=%b busy=%b, required 1 1", tx16, b16);
    end
    stream_check(1'b0, 2, "single", lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL single_latency: start bit %0d edges after accept, required 1", lat);
    end
  endtask

  task automatic test_random();
    int w8, lat;
    logic [15:0] w;
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = 16'($urandom);
      exp_q.push_back({48'h0, w});
      push16(w, w8);
      v16 = 1'b0;
      stream_check(1'b0, 2, "random", lat);
    end
  endtask

  // Valid held high for 6 words: one word goes straight to the shifter, so
  // DEPTH+1 are taken on consecutive edges before ready drops.
  task automatic test_back_to_back();
    logic [15:0] words[6];
    int imm = 0;
    bit run = 1'b1;
    int lat;
    for (int i = 0; i < 6; i++) begin
      words[i] = 16'($urandom);
      exp_q.push_back({48'h0, words[i]});
    end
    fork
      begin
        int w8;
        for (int i = 0; i < 6; i++) begin
          push16(words[i], w8);
          if (run && w8 == 0) imm++;
          else run = 1'b0;
        end
        v16 = 1'b0;
      end
      stream_check(1'b0, 2, "back_to_back", lat);
    join
    checks++;
    if (imm != DEPTH + 1) begin
      errors++;
      $display("FAIL b2b_immediate_accepts: %0d, required %0d", imm, DEPTH + 1);
    end
  endtask

  // Occupancy DEPTH-1 while a frame runs; a new word arrives on the pop edge.
  task automatic test_simul();
    logic [15:0] w[5];
    int lat;
    for (int i = 0; i < 5; i++) begin
      w[i] = 16'($urandom);
      exp_q.push_back({48'h0, w[i]});
    end
    fork
      begin
        v16 = 1'b1;
        d16 = w[0];
        checks++;
        if (r16 !== 1'b1) begin
          errors++;
          $display("FAIL simul_ready_start: s_tready=%b, required 1", r16);
        end
        for (int i = 1; i < 4; i++) begin
          @(negedge clk);
          d16 = w[i];
        end
        @(negedge clk);
        v16 = 1'b0;
        checks++;
        if (r16 !== 1'b1) begin
          errors++;
          $display("FAIL simul_ready_occ3: s_tready=%b, required 1", r16);
        end
        repeat (197) @(negedge clk);
        v16 = 1'b1;
        d16 = w[4];
        @(negedge clk);
        v16 = 1'b0;
        checks++;
        if (r16 !== 1'b1) begin
          errors++;
          $display("FAIL simul_push_pop_ready: s_tready=%b, required 1", r16);
        end
        @(negedge clk);
        checks++;
        if (r16 !== 1'b1) begin
          errors++;
          $display("FAIL simul_ready_after: s_tready=%b, required 1", r16);
        end
      end
      stream_check(1'b0, 2, "simul", lat);
    join
  endtask

  task automatic test_reset_mid();
    logic [15:0] w0 = 16'($urandom);
    int hi = 0, bz = 0, w8, lat;
    v16 = 1'b1;
    d16 = w0;
    @(negedge clk);
    d16 = 16'($urandom);
    @(negedge clk);
    v16 = 1'b0;
    repeat (44) @(negedge clk);
    checks++;
    if (tx16 !== w0[3]) begin
      errors++;
      $display("FAIL mid_bit3: line=%b, required %b", tx16, w0[3]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx16 !== 1'b1 || b16 !== 1'b0 || r16 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: line=%b busy=%b ready=%b, required 1 0 0", tx16, b16, r16);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx16 === 1'b1) hi++;
      if (b16 !== 1'b0) bz++;
    end
    checks++;
    if (hi != 30 || bz != 0 || r16 !== 1'b1) begin
      errors++;
      $display("FAIL mid_after_reset_idle: high=%0d busy_cycles=%0d ready=%b, required 30 0 1", hi, bz, r16);
    end
    exp_q.push_back(64'h00FF);
    push16(16'h00FF, w8);
    v16 = 1'b0;
    stream_check(1'b0, 2, "post_reset", lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL post_reset_latency: %0d, required 1", lat);
    end
  endtask

  task automatic test_wide64();
    int lat;
    exp_q.push_back(64'h0807060504030201);
    v64 = 1'b1;
    d64 = 64'h0807060504030201;
    checks++;
    if (r64 !== 1'b1) begin
      errors++;
      $display("FAIL wide_ready: s_tready=%b, required 1", r64);
    end
    @(negedge clk);
    v64 = 1'b0;
    stream_check(1'b1, 8, "wide64", lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL wide_latency: %0d, required 1", lat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_simul();
    test_reset_mid();
    test_wide64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
